// File: rtl/gpio_mmio_pkg.sv
// Shared register offsets and address-decode helper for the memory-mapped GPIO block.
package gpio_mmio_pkg;

    localparam logic [1:0] OFS_DATA_OUT = 2'd0;
    localparam logic [1:0] OFS_DATA_IN  = 2'd1;
    localparam logic [1:0] OFS_STATUS   = 2'd2;
    localparam logic [1:0] OFS_EN       = 2'd3;

    localparam int CHAN_STRIDE = 16;

    typedef struct packed {
        logic [3:0] chan;
        logic [1:0] reg_sel;
    } decode_t;

    // Byte-offset bits [1:0] never take part in the decode.
    function automatic decode_t decode_offset(input logic [7:2] ofs);
        decode_t d;
        d.chan    = ofs[7:4];
        d.reg_sel = ofs[3:2];
        return d;
    endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: output latch, input synchroniser, sticky rising-edge status,
// interrupt mask and the per-channel read mux.
module gpio_channel
    import gpio_mmio_pkg::*;
#(
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [1:0]            reg_sel,
    input  logic [GPIO_WIDTH-1:0] wr_data,
    input  logic [GPIO_WIDTH-1:0] pins,
    output logic [GPIO_WIDTH-1:0] data_out,
    output logic                  irq_partial,
    output logic [GPIO_WIDTH-1:0] rd_data
);

    logic [GPIO_WIDTH-1:0] data_out_q;
    logic [GPIO_WIDTH-1:0] en_q;
    logic [GPIO_WIDTH-1:0] status_q;
    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] sync3_q;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] w1c;

    assign rise = sync2_q & ~sync3_q;
    assign w1c  = (wr_en && reg_sel == OFS_STATUS) ? wr_data : '0;

    // A rise and a clear on the same bit in one edge leave the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            en_q       <= '0;
            status_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
        end else begin
            sync1_q  <= pins;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            status_q <= (status_q & ~w1c) | rise;
            if (wr_en && reg_sel == OFS_DATA_OUT) data_out_q <= wr_data;
            if (wr_en && reg_sel == OFS_EN)       en_q       <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            OFS_DATA_OUT: rd_data = data_out_q;
            OFS_DATA_IN:  rd_data = sync2_q;
            OFS_STATUS:   rd_data = status_q;
            OFS_EN:       rd_data = en_q;
            default:      rd_data = '0;
        endcase
    end

    assign data_out    = data_out_q;
    assign irq_partial = |(status_q & en_q);

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO block: window decode, N_PORTS channel instances, read-data
// return and the registered interrupt request.
module gpio_mmio
    import gpio_mmio_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    GPIO_WIDTH = 8,
    parameter int                    N_PORTS    = 2,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         Address_i,
    input  logic                          Write_Enable_i,
    input  logic [DATA_WIDTH-1:0]         Write_Data_i,
    output logic [DATA_WIDTH-1:0]         Read_Data_o,
    output logic                          Hit_o,
    input  logic [N_PORTS*GPIO_WIDTH-1:0] GPIO_i,
    output logic [N_PORTS*GPIO_WIDTH-1:0] GPIO_o,
    output logic                          Irq_o
);

    localparam logic [DATA_WIDTH-1:0] WINDOW = DATA_WIDTH'(CHAN_STRIDE * N_PORTS);

    logic [DATA_WIDTH-1:0] offset;
    decode_t               dec;
    logic                  hit;
    logic [GPIO_WIDTH-1:0] rd_arr [N_PORTS];
    logic [N_PORTS-1:0]    irq_arr;
    logic [GPIO_WIDTH-1:0] rd_sel;
    logic                  irq_q;
    logic                  unused_wdata;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign offset = Address_i - BASE_ADDR;
    assign dec    = decode_offset(offset[7:2]);
    assign hit    = offset < WINDOW;
    assign Hit_o  = hit;

    assign unused_wdata = ^Write_Data_i;

    for (genvar c = 0; c < N_PORTS; c++) begin : g_chan
        gpio_channel #(
            .GPIO_WIDTH (GPIO_WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (Write_Enable_i && hit && dec.chan == 4'(c)),
            .reg_sel     (dec.reg_sel),
            .wr_data     (Write_Data_i[GPIO_WIDTH-1:0]),
            .pins        (GPIO_i[c*GPIO_WIDTH +: GPIO_WIDTH]),
            .data_out    (GPIO_o[c*GPIO_WIDTH +: GPIO_WIDTH]),
            .irq_partial (irq_arr[c]),
            .rd_data     (rd_arr[c])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < N_PORTS; c++) begin
            if (dec.chan == 4'(c)) rd_sel = rd_arr[c];
        end
        Read_Data_o = '0;
        if (hit) Read_Data_o[GPIO_WIDTH-1:0] = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |irq_arr;
    end

    assign Irq_o = irq_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Bench for gpio_mmio: directed vector table for the register-level corner cases,
// then randomized bus/pin traffic checked against a sample-history reference model.
module tb_gpio_mmio;

    localparam int          DW   = 32;
    localparam int          GW   = 8;
    localparam int          NP   = 2;
    localparam int          PW   = NP * GW;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] Address_i;
    logic          Write_Enable_i;
    logic [DW-1:0] Write_Data_i;
    logic [DW-1:0] Read_Data_o;
    logic          Hit_o;
    logic [PW-1:0] GPIO_i;
    logic [PW-1:0] GPIO_o;
    logic          Irq_o;

    always #5 clk = ~clk;

    gpio_mmio #(
        .DATA_WIDTH (DW),
        .GPIO_WIDTH (GW),
        .N_PORTS    (NP),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Address_i      (Address_i),
        .Write_Enable_i (Write_Enable_i),
        .Write_Data_i   (Write_Data_i),
        .Read_Data_o    (Read_Data_o),
        .Hit_o          (Hit_o),
        .GPIO_i         (GPIO_i),
        .GPIO_o         (GPIO_o),
        .Irq_o          (Irq_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents per channel plus the last three pin samples
    // (index 0 = most recent edge).
    logic [GW-1:0] m_dout   [NP];
    logic [GW-1:0] m_en     [NP];
    logic [GW-1:0] m_status [NP];
    logic [PW-1:0] m_hist   [3];
    logic          m_irq;

    function automatic logic model_hit(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(16 * NP);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off;
        int c, r;
        off = addr - BASE;
        if (!model_hit(addr)) return 32'h0;
        c = int'(off / 16);
        r = int'((off % 16) / 4);
        case (r)
            0:       return 32'(m_dout[c]);
            1:       return 32'(m_hist[1][c*GW +: GW]);
            2:       return 32'(m_status[c]);
            default: return 32'(m_en[c]);
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [PW-1:0] pins);
        logic [31:0]   off;
        logic          any;
        logic [GW-1:0] rise;
        int c, r;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_dout[i] = '0; m_en[i] = '0; m_status[i] = '0;
            end
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_irq = 1'b0;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < NP; i++) any = any | (|(m_status[i] & m_en[i]));
        off = addr - BASE;
        c = int'(off / 16);
        r = int'((off % 16) / 4);
        for (int i = 0; i < NP; i++) begin
            rise = m_hist[1][i*GW +: GW] & ~m_hist[2][i*GW +: GW];
            if (we && model_hit(addr) && c == i && r == 2)
                m_status[i] = m_status[i] & ~wd[GW-1:0];
            m_status[i] = m_status[i] | rise;
            if (we && model_hit(addr) && c == i && r == 0) m_dout[i] = wd[GW-1:0];
            if (we && model_hit(addr) && c == i && r == 3) m_en[i]   = wd[GW-1:0];
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = pins;
        m_irq = any;
    endtask

    function automatic logic [PW-1:0] model_gpio();
        logic [PW-1:0] g;
        for (int i = 0; i < NP; i++) g[i*GW +: GW] = m_dout[i];
        return g;
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [PW-1:0] pins);
        reset          = rst;
        Write_Enable_i = we;
        Address_i      = addr;
        Write_Data_i   = wd;
        GPIO_i         = pins;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(reset, Write_Enable_i, Address_i, Write_Data_i, GPIO_i);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] pins;
        logic        chk_rd;
        logic        exp_hit;
        logic [31:0] exp_rd;
        logic [15:0] exp_gpio;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [15:0] pins,
                                input logic chk_rd, input logic exp_hit,
                                input logic [31:0] exp_rd, input logic [15:0] exp_gpio,
                                input logic exp_irq);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wdata = wd; v.pins = pins;
        v.chk_rd = chk_rd; v.exp_hit = exp_hit; v.exp_rd = exp_rd;
        v.exp_gpio = exp_gpio; v.exp_irq = exp_irq;
        return v;
    endfunction

    initial begin
        logic [31:0] rand_addr;
        logic [PW-1:0] rand_pins;
        int sel;

        for (int i = 0; i < NP; i++) begin
            m_dout[i] = '0; m_en[i] = '0; m_status[i] = '0;
        end
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_irq = 1'b0;

        // Each row: bus read checked before its edge, pins/irq checked after it.
        // Reset held two edges with all pins high.
        vecs.push_back(mk(1, 0, BASE,         0, 16'hFFFF, 0, 1, 0,    16'h0000, 0));
        vecs.push_back(mk(1, 0, BASE,         0, 16'hFFFF, 1, 1, 0,    16'h0000, 0));
        // Every register of every channel reads zero after release.
        for (int a = 0; a < 32; a += 4)
            vecs.push_back(mk(0, 0, BASE + 32'(a), 0, 16'h0000, 1, 1, 0, 16'h0000, 0));
        // Channel 1 DATA_OUT write and read-back; channel 0 stays at 0.
        vecs.push_back(mk(0, 1, BASE + 32'h10, 32'hA5, 16'h0000, 1, 1, 0,     16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h10, 0,      16'h0000, 1, 1, 32'hA5, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE,          0,      16'h0000, 1, 1, 0,     16'hA500, 0));
        // Pin 0 rises before edge k: DATA_IN at k+1, STATUS at k+2, no irq with EN=0.
        vecs.push_back(mk(0, 0, BASE + 32'h4, 0, 16'h0001, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h4, 0, 16'h0001, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h4, 0, 16'h0001, 1, 1, 1, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h8, 0, 16'h0001, 1, 1, 1, 16'hA500, 0));
        // Enable bit 0: irq follows STATUS&EN by one edge; W1C drops it one edge later.
        vecs.push_back(mk(0, 1, BASE + 32'hC, 32'h01, 16'h0001, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'hC, 0,      16'h0001, 1, 1, 1, 16'hA500, 1));
        vecs.push_back(mk(0, 1, BASE + 32'h8, 32'h01, 16'h0001, 1, 1, 1, 16'hA500, 1));
        vecs.push_back(mk(0, 0, BASE + 32'h8, 0,      16'h0001, 1, 1, 0, 16'hA500, 0));
        // Bit 3 rises; W1C of bit 3 lands on the edge its flag sets.
        vecs.push_back(mk(0, 0, BASE + 32'h8, 0,      16'h0009, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h4, 0,      16'h0009, 1, 1, 1, 16'hA500, 0));
        vecs.push_back(mk(0, 1, BASE + 32'h8, 32'h08, 16'h0009, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h8, 0,      16'h0009, 1, 1, 8, 16'hA500, 0));
        // Out-of-window writes and a DATA_IN write change nothing.
        vecs.push_back(mk(0, 1, BASE + 32'h20, 32'hFF, 16'h0009, 1, 0, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 1, BASE - 32'h4,  32'hFF, 16'h0009, 1, 0, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 1, BASE + 32'h4,  32'hFF, 16'h0009, 1, 1, 9, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE,          0,      16'h0009, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'hC,  0,      16'h0009, 1, 1, 1, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h1C, 0,      16'h0009, 1, 1, 0, 16'hA500, 0));
        vecs.push_back(mk(0, 0, BASE + 32'h4,  0,      16'h0009, 1, 1, 9, 16'hA500, 0));
        // Reset during a write: the write is lost and everything clears.
        vecs.push_back(mk(1, 1, BASE,          32'h3C, 16'h0009, 1, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, BASE,          0,      16'h0009, 1, 1, 0, 16'h0000, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pins);
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_hit", i), 32'(Hit_o), 32'(vecs[i].exp_hit));
                check($sformatf("vec%0d_rdata", i), Read_Data_o, vecs[i].exp_rd);
            end
            tick();
            check($sformatf("vec%0d_gpio", i), 32'(GPIO_o), 32'(vecs[i].exp_gpio));
            check($sformatf("vec%0d_irq", i), 32'(Irq_o), 32'(vecs[i].exp_irq));
        end

        // Randomized traffic against the reference model.
        rand_pins = GPIO_i;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rand_addr = BASE + 32'(16 * NP) + $urandom_range(0, 63);
            else if (sel == 1) rand_addr = BASE - $urandom_range(1, 64);
            else               rand_addr = BASE + $urandom_range(0, 16 * NP - 1);
            if ($urandom_range(0, 3) == 0) rand_pins = PW'($urandom);
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), rand_addr,
                  $urandom, rand_pins);
            check("rand_hit", 32'(Hit_o), 32'(model_hit(Address_i)));
            check("rand_rdata", Read_Data_o, model_read(Address_i));
            tick();
            check("rand_gpio", 32'(GPIO_o), 32'(model_gpio()));
            check("rand_irq", 32'(Irq_o), 32'(m_irq));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
